mem_port_sequencer: RTL and testbench
=====================================

// Module: mem_port_sequencer
// PURPOSE
//   Shares one byte-wide, single-port synchronous RAM between the CPU fetch port, CPU data-read port,
//   CPU data-write port and a byte loader port. Sequences multi-byte accesses: 3-byte fetch, 2-byte read,
//   1-2 byte write. Sits between cpu and a narrow RAM; produces ivalid and the other completion strobes.
// PARAMETERS
//   ADDR_W        16  address width; all byte addresses wrap modulo 2**ADDR_W
//   STARVE_LIMIT   4  consecutive non-fetch grants while iread_req pending before fetch is forced (1..15)
// PORTS
//   clk          in   1       system clock, rising edge
//   reset        in   1       asynchronous, active-low reset (0 = in reset)
//   iread_req    in   1       fetch request; hold with iread_addr stable until ivalid
//   iread_addr   in   ADDR_W  fetch byte address
//   iread_data   out  24      fetched instruction, little-endian
//   ivalid       out  1       one-cycle fetch completion strobe
//   dread_req    in   1       data read request; hold until dread_valid
//   dread_addr   in   ADDR_W  data read byte address
//   dread_data   out  16      read data, little-endian
//   dread_valid  out  1       one-cycle read completion strobe
//   dwrite_addr  in   ADDR_W  write byte address
//   dwrite_data  in   16      write data; [7:0] -> addr, [15:8] -> addr+1
//   dwrite_en    in   2       byte enables; nonzero = write request; hold until dwrite_done
//   dwrite_done  out  1       one-cycle write completion strobe
//   ld_req/ld_addr/ld_data  in 1/ADDR_W/8   loader single-byte write request
//   ld_ack       out  1       one-cycle loader completion strobe
//   mem_addr     out  ADDR_W  RAM address; mem_wdata out 8; mem_we out 1
//   mem_rdata    in   8       RAM read data, valid one cycle after mem_addr
//   busy         out  1       high whenever state != IDLE
// BEHAVIOUR
// - Reset (async assert, sync release): state IDLE, all outputs 0, starve_cnt 0; any op aborts with no strobe.
// - FSM: IDLE -> {LOAD, DWRITE, DREAD, IFETCH} -> DONE -> IDLE. Arbitration only in IDLE.
// - Priority: ld > dwrite > dread > ifetch. If starve_cnt == STARVE_LIMIT and iread_req: ifetch beats
//   dwrite/dread, never ld. starve_cnt +1 (saturating) per non-fetch grant with iread_req high; 0 on fetch grant.
// - Grant edge latches addr/data/enables into internal regs; later input changes are ignored.
// - IFETCH: 3 cycles driving A, A+1, A+2; bytes captured the following cycle. Next: DONE with ivalid=1,
//   iread_data = {m[A+2],m[A+1],m[A]}. ivalid is high in the 4th cycle after the grant edge.
// - DREAD: 2 cycles (A, A+1); DONE with dread_valid=1, dread_data = {m[A+1],m[A]}.
// - DWRITE: en=01 -> 1 cycle, low byte at A; en=10 -> 1 cycle, high byte at A+1; en=11 -> 2 cycles, A then A+1.
//   mem_we high only in write cycles. DONE: dwrite_done=1.
// - LOAD: 1 write cycle; DONE: ld_ack=1.
// - DONE lasts exactly 1 cycle, no grant, so a requester drops/changes its request in the strobe cycle.
// - Request dropped mid-op: op completes, strobe still pulses. Data outputs hold until the next completion of
//   the same port.
// - Address arithmetic ADDR_W bits: A=16'hFFFF fetch reads FFFF,0000,0001.
// - mem_addr = 0, mem_wdata = 0 and mem_we = 0 in IDLE and DONE.
// STRUCTURE
// - Package mem_seq_pkg: state enum (IDLE, IFETCH, DREAD, DWRITE, LOAD, DONE), requester-id enum,
//   op-length constants (FETCH_BYTES=3, DREAD_BYTES=2).
// - Sub-module mem_seq_prio: fixed-priority grant with starvation counter (combinational grant,
//   registered starve_cnt). Top holds FSM, byte counter, capture regs.
// TESTING
// 1 Preload m[0x10..0x12]=11,22,33; iread_req, A=0x0010 -> ivalid 1 cycle, 4 cycles after grant,
//   iread_data=0x332211.
// 2 dwrite_en=11, A=0x0020, data=0xBEEF -> 2 mem_we cycles (0x20=EF, 0x21=BE), dwrite_done; dread 0x20 -> 0xBEEF.
// 3 dwrite_en=10, A=0x0030 -> single write 0x31; 0x30 unchanged. A=0xFFFF fetch -> bytes FFFF,0000,0001.
// 4 ld_req, dwrite_en, dread_req, iread_req same cycle -> grant order ld, dwrite, dread, fetch; one DONE
//   cycle between each.
// 5 iread_req held, dread_req re-raised after every valid -> fetch forced after exactly 4 dread grants.
// 6 Assert reset mid-IFETCH -> outputs 0 asynchronously, no ivalid; after release a held request restarts
//   cleanly.

Source files
------------

// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the memory port sequencer.
//   state_t    : sequencer FSM states
//   req_id_t   : requester identity produced by the arbiter
//   FETCH_BYTES / DREAD_BYTES : multi-byte operation lengths
package mem_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IFETCH,
        ST_DREAD,
        ST_DWRITE,
        ST_LOAD,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        REQ_NONE,
        REQ_LD,
        REQ_DWRITE,
        REQ_DREAD,
        REQ_IFETCH
    } req_id_t;

    localparam int unsigned FETCH_BYTES = 3;
    localparam int unsigned DREAD_BYTES = 2;
    localparam int unsigned CNT_W       = 2;
    localparam int unsigned STARVE_W    = 4;

endpackage

// File: rtl/mem_seq_prio.sv
// Fixed-priority arbiter with fetch starvation protection.
//   arb_en      : arbitration allowed this cycle (sequencer idle)
//   *_req       : pending requests from the four ports
//   grant_c     : combinational grant (REQ_NONE when nothing granted)
//   starve_cnt  : consecutive non-fetch grants taken while a fetch was pending
module mem_seq_prio
    import mem_seq_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                arb_en,
    input  logic                ld_req,
    input  logic                dwrite_req,
    input  logic                dread_req,
    input  logic                iread_req,
    output req_id_t             grant_c,
    output logic [STARVE_W-1:0] starve_cnt
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    logic force_fetch;

    assign force_fetch = iread_req && (starve_cnt == LIMIT);

    // Loader always wins; a starved fetch jumps ahead of data traffic only.
    always_comb begin
        grant_c = REQ_NONE;
        if (arb_en) begin
            if (ld_req)           grant_c = REQ_LD;
            else if (force_fetch) grant_c = REQ_IFETCH;
            else if (dwrite_req)  grant_c = REQ_DWRITE;
            else if (dread_req)   grant_c = REQ_DREAD;
            else if (iread_req)   grant_c = REQ_IFETCH;
        end
    end

    // Saturates at the limit so the forcing compare stays exact.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (grant_c == REQ_IFETCH) begin
            starve_cnt <= '0;
        end else if (grant_c != REQ_NONE && iread_req && starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
        end
    end

endmodule

// File: rtl/mem_port_sequencer.sv
// Shares a byte-wide synchronous RAM between fetch, data-read, data-write
// and loader ports, sequencing multi-byte accesses one byte per cycle.
//   iread_*  : 3-byte little-endian instruction fetch, ivalid strobe
//   dread_*  : 2-byte little-endian data read, dread_valid strobe
//   dwrite_* : 1-2 byte write selected by byte enables, dwrite_done strobe
//   ld_*     : single-byte loader write, ld_ack strobe
//   mem_*    : RAM interface, read data arrives one cycle after mem_addr
//   busy     : sequencer not idle
module mem_port_sequencer
    import mem_seq_pkg::*;
#(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iread_req,
    input  logic [ADDR_W-1:0] iread_addr,
    output logic [23:0]       iread_data,
    output logic              ivalid,
    input  logic              dread_req,
    input  logic [ADDR_W-1:0] dread_addr,
    output logic [15:0]       dread_data,
    output logic              dread_valid,
    input  logic [ADDR_W-1:0] dwrite_addr,
    input  logic [15:0]       dwrite_data,
    input  logic [1:0]        dwrite_en,
    output logic              dwrite_done,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              ld_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    state_t              state_q, state_d;
    req_id_t             grant_c;
    logic [STARVE_W-1:0] starve_cnt;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         wdata_q, wdata_d;
    logic [1:0]          en_q, en_d;
    logic [15:0]         cap_q, cap_d;
    logic [23:0]         iread_hold_q;
    logic [15:0]         dread_hold_q;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic [7:0]          mem_wdata_d;
    logic                mem_we_d;
    logic                ivalid_d, dread_valid_d, dwrite_done_d, ld_ack_d;

    mem_seq_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
        .clk        (clk),
        .reset      (reset),
        .arb_en     (state_q == ST_IDLE),
        .ld_req     (ld_req),
        .dwrite_req (|dwrite_en),
        .dread_req  (dread_req),
        .iread_req  (iread_req),
        .grant_c    (grant_c),
        .starve_cnt (starve_cnt)
    );

    // Last byte of a read is still on mem_rdata in the strobe cycle, so it
    // bypasses the capture register; the hold copies keep data afterwards.
    assign iread_data = ivalid      ? {mem_rdata, cap_q}      : iread_hold_q;
    assign dread_data = dread_valid ? {mem_rdata, cap_q[7:0]} : dread_hold_q;

    // Next state plus next values of the registered RAM/strobe outputs.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        en_d          = en_q;
        cap_d         = cap_q;
        mem_addr_d    = '0;
        mem_wdata_d   = '0;
        mem_we_d      = 1'b0;
        ivalid_d      = 1'b0;
        dread_valid_d = 1'b0;
        dwrite_done_d = 1'b0;
        ld_ack_d      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                unique case (grant_c)
                    REQ_LD: begin
                        state_d     = ST_LOAD;
                        mem_addr_d  = ld_addr;
                        mem_wdata_d = ld_data;
                        mem_we_d    = 1'b1;
                    end
                    REQ_DWRITE: begin
                        state_d  = ST_DWRITE;
                        addr_d   = dwrite_addr;
                        wdata_d  = dwrite_data;
                        en_d     = dwrite_en;
                        cnt_d    = CNT_W'(1);
                        mem_we_d = 1'b1;
                        if (dwrite_en[0]) begin
                            mem_addr_d  = dwrite_addr;
                            mem_wdata_d = dwrite_data[7:0];
                        end else begin
                            mem_addr_d  = dwrite_addr + ADDR_W'(1);
                            mem_wdata_d = dwrite_data[15:8];
                        end
                    end
                    REQ_DREAD: begin
                        state_d    = ST_DREAD;
                        addr_d     = dread_addr;
                        cnt_d      = CNT_W'(1);
                        mem_addr_d = dread_addr;
                    end
                    REQ_IFETCH: begin
                        state_d    = ST_IFETCH;
                        addr_d     = iread_addr;
                        cnt_d      = CNT_W'(1);
                        mem_addr_d = iread_addr;
                    end
                    default: ;
                endcase
            end
            ST_IFETCH, ST_DREAD: begin
                // cnt_q = bytes addressed so far; byte cnt_q-2 is on mem_rdata.
                if (cnt_q == CNT_W'(2))      cap_d[7:0]  = mem_rdata;
                else if (cnt_q == CNT_W'(3)) cap_d[15:8] = mem_rdata;
                if (cnt_q < ((state_q == ST_IFETCH) ? CNT_W'(FETCH_BYTES) : CNT_W'(DREAD_BYTES))) begin
                    mem_addr_d = addr_q + ADDR_W'(cnt_q);
                    cnt_d      = cnt_q + CNT_W'(1);
                end else begin
                    state_d       = ST_DONE;
                    ivalid_d      = (state_q == ST_IFETCH);
                    dread_valid_d = (state_q == ST_DREAD);
                end
            end
            ST_DWRITE: begin
                if (en_q == 2'b11 && cnt_q == CNT_W'(1)) begin
                    mem_addr_d  = addr_q + ADDR_W'(1);
                    mem_wdata_d = wdata_q[15:8];
                    mem_we_d    = 1'b1;
                    cnt_d       = CNT_W'(2);
                end else begin
                    state_d       = ST_DONE;
                    dwrite_done_d = 1'b1;
                end
            end
            ST_LOAD: begin
                state_d  = ST_DONE;
                ld_ack_d = 1'b1;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, capture and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            en_q         <= '0;
            cap_q        <= '0;
            iread_hold_q <= '0;
            dread_hold_q <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_we       <= 1'b0;
            ivalid       <= 1'b0;
            dread_valid  <= 1'b0;
            dwrite_done  <= 1'b0;
            ld_ack       <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            en_q        <= en_d;
            cap_q       <= cap_d;
            mem_addr    <= mem_addr_d;
            mem_wdata   <= mem_wdata_d;
            mem_we      <= mem_we_d;
            ivalid      <= ivalid_d;
            dread_valid <= dread_valid_d;
            dwrite_done <= dwrite_done_d;
            ld_ack      <= ld_ack_d;
            busy        <= (state_d != ST_IDLE);
            if (ivalid)      iread_hold_q <= {mem_rdata, cap_q};
            if (dread_valid) dread_hold_q <= {mem_rdata, cap_q[7:0]};
        end
    end

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Directed bench for mem_port_sequencer with a behavioural byte RAM.
module tb_mem_port_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iread_req;
    logic [15:0] iread_addr;
    logic [23:0] iread_data;
    logic        ivalid;
    logic        dread_req;
    logic [15:0] dread_addr;
    logic [15:0] dread_data;
    logic        dread_valid;
    logic [15:0] dwrite_addr;
    logic [15:0] dwrite_data;
    logic [1:0]  dwrite_en;
    logic        dwrite_done;
    logic        ld_req;
    logic [15:0] ld_addr;
    logic [7:0]  ld_data;
    logic        ld_ack;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem [0:65535];
    logic [15:0] wlog_addr [$];
    logic [7:0]  wlog_data [$];

    always #5 clk = ~clk;

    mem_port_sequencer #(.ADDR_W(16), .STARVE_LIMIT(4)) dut (
        .clk         (clk),
        .reset       (rst_n),
        .iread_req   (iread_req),
        .iread_addr  (iread_addr),
        .iread_data  (iread_data),
        .ivalid      (ivalid),
        .dread_req   (dread_req),
        .dread_addr  (dread_addr),
        .dread_data  (dread_data),
        .dread_valid (dread_valid),
        .dwrite_addr (dwrite_addr),
        .dwrite_data (dwrite_data),
        .dwrite_en   (dwrite_en),
        .dwrite_done (dwrite_done),
        .ld_req      (ld_req),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_ack      (ld_ack),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_rdata   (mem_rdata),
        .busy        (busy)
    );

    // Synchronous single-port RAM, read data one cycle after address.
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            wlog_addr.push_back(mem_addr);
            wlog_data.push_back(mem_wdata);
        end
        mem_rdata <= mem[mem_addr];
    end

    task automatic test_reset();
        rst_n = 1'b0;
        iread_req = 0; iread_addr = 0; dread_req = 0; dread_addr = 0;
        dwrite_addr = 0; dwrite_data = 0; dwrite_en = 0;
        ld_req = 0; ld_addr = 0; ld_data = 0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, ivalid, dread_valid, dwrite_done, ld_ack, mem_we} !== 6'b0) begin
            bad++; $display("FAIL reset_ctrl: got %b expected 000000",
                            {busy, ivalid, dread_valid, dwrite_done, ld_ack, mem_we});
        end
        total++;
        if ({mem_addr, mem_wdata} !== 24'h0) begin
            bad++; $display("FAIL reset_mem: got %h expected 000000", {mem_addr, mem_wdata});
        end
        total++;
        if ({iread_data, dread_data} !== 40'h0) begin
            bad++; $display("FAIL reset_data: got %h expected 0", {iread_data, dread_data});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fetch();
        int n = 0;
        mem[16'h0010] = 8'h11; mem[16'h0011] = 8'h22; mem[16'h0012] = 8'h33;
        iread_addr = 16'h0010; iread_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); n++;
            if (ivalid) break;
        end
        iread_req = 1'b0; iread_addr = 16'h1234;
        total++;
        if (n !== 4) begin bad++; $display("FAIL fetch_latency: got %0d expected 4", n); end
        total++;
        if (iread_data !== 24'h332211) begin
            bad++; $display("FAIL fetch_data: got %h expected 332211", iread_data);
        end
        total++;
        if ({mem_addr, mem_we} !== 17'h0) begin
            bad++; $display("FAIL done_mem_idle: got %h expected 0", {mem_addr, mem_we});
        end
        @(negedge clk);
        total++;
        if (ivalid !== 1'b0 || iread_data !== 24'h332211) begin
            bad++; $display("FAIL fetch_hold: got ivalid=%b data=%h expected 0/332211", ivalid, iread_data);
        end
    endtask

    task automatic test_dwrite_dread();
        int n = 0;
        wlog_addr.delete(); wlog_data.delete();
        dwrite_addr = 16'h0020; dwrite_data = 16'hBEEF; dwrite_en = 2'b11;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); n++;
            if (dwrite_done) break;
        end
        dwrite_en = 2'b00;
        total++;
        if (n !== 3) begin bad++; $display("FAIL dwrite_latency: got %0d expected 3", n); end
        total++;
        if (wlog_addr.size() !== 2) begin
            bad++; $display("FAIL dwrite_count: got %0d expected 2", wlog_addr.size());
        end else begin
            total++;
            if ({wlog_addr[0], wlog_data[0], wlog_addr[1], wlog_data[1]} !== 48'h0020EF_0021BE) begin
                bad++; $display("FAIL dwrite_bytes: got %h %h %h %h expected 0020 ef 0021 be",
                                wlog_addr[0], wlog_data[0], wlog_addr[1], wlog_data[1]);
            end
        end
        @(negedge clk);
        n = 0;
        dread_addr = 16'h0020; dread_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); n++;
            if (dread_valid) break;
        end
        dread_req = 1'b0;
        total++;
        if (n !== 3) begin bad++; $display("FAIL dread_latency: got %0d expected 3", n); end
        total++;
        if (dread_data !== 16'hBEEF) begin
            bad++; $display("FAIL dread_data: got %h expected beef", dread_data);
        end
        @(negedge clk);
    endtask

    task automatic test_partial_wrap();
        mem[16'h0030] = 8'h5A; mem[16'h0031] = 8'h00;
        mem[16'h0040] = 8'h00; mem[16'h0041] = 8'h66;
        wlog_addr.delete(); wlog_data.delete();
        dwrite_addr = 16'h0030; dwrite_data = 16'h7733; dwrite_en = 2'b10;
        for (int i = 0; i < 20; i++) begin @(negedge clk); if (dwrite_done) break; end
        dwrite_en = 2'b00;
        @(negedge clk);
        dwrite_addr = 16'h0040; dwrite_data = 16'h1299; dwrite_en = 2'b01;
        for (int i = 0; i < 20; i++) begin @(negedge clk); if (dwrite_done) break; end
        dwrite_en = 2'b00;
        @(negedge clk);
        total++;
        if (wlog_addr.size() !== 2) begin
            bad++; $display("FAIL partial_count: got %0d expected 2", wlog_addr.size());
        end else begin
            total++;
            if ({wlog_addr[0], wlog_data[0], wlog_addr[1], wlog_data[1]} !== 48'h003177_004099) begin
                bad++; $display("FAIL partial_bytes: got %h %h %h %h expected 0031 77 0040 99",
                                wlog_addr[0], wlog_data[0], wlog_addr[1], wlog_data[1]);
            end
        end
        total++;
        if ({mem[16'h0030], mem[16'h0041]} !== 16'h5A66) begin
            bad++; $display("FAIL partial_untouched: got %h expected 5a66", {mem[16'h0030], mem[16'h0041]});
        end
        mem[16'hFFFF] = 8'hAA; mem[16'h0000] = 8'hBB; mem[16'h0001] = 8'hCC;
        iread_addr = 16'hFFFF; iread_req = 1'b1;
        for (int i = 0; i < 20; i++) begin @(negedge clk); if (ivalid) break; end
        iread_req = 1'b0;
        total++;
        if (iread_data !== 24'hCCBBAA || ivalid !== 1'b1) begin
            bad++; $display("FAIL fetch_wrap: got %b/%h expected 1/ccbbaa", ivalid, iread_data);
        end
        @(negedge clk);
        dread_addr = 16'hFFFF; dread_req = 1'b1;
        for (int i = 0; i < 20; i++) begin @(negedge clk); if (dread_valid) break; end
        dread_req = 1'b0;
        total++;
        if (dread_data !== 16'hBBAA || dread_valid !== 1'b1) begin
            bad++; $display("FAIL dread_wrap: got %b/%h expected 1/bbaa", dread_valid, dread_data);
        end
        @(negedge clk);
    endtask

    task automatic test_priority();
        int ord [4];
        int at  [4];
        int k = 0;
        int cyc = 0;
        logic [15:0] rd;
        logic [23:0] fd;
        rd = '0; fd = '0;
        for (int i = 0; i < 4; i++) begin ord[i] = 0; at[i] = 0; end
        ld_addr = 16'h0050; ld_data = 8'h5C; ld_req = 1'b1;
        dwrite_addr = 16'h0060; dwrite_data = 16'h00A5; dwrite_en = 2'b01;
        dread_addr = 16'h0010; dread_req = 1'b1;
        iread_addr = 16'h0010; iread_req = 1'b1;
        for (int i = 0; i < 40 && k < 4; i++) begin
            @(negedge clk); cyc++;
            if (ld_ack)      begin ord[k] = 1; at[k] = cyc; k++; ld_req = 1'b0; end
            if (dwrite_done && k < 4) begin ord[k] = 2; at[k] = cyc; k++; dwrite_en = 2'b00; end
            if (dread_valid && k < 4) begin ord[k] = 3; at[k] = cyc; k++; dread_req = 1'b0; rd = dread_data; end
            if (ivalid && k < 4)      begin ord[k] = 4; at[k] = cyc; k++; iread_req = 1'b0; fd = iread_data; end
        end
        ld_req = 1'b0; dwrite_en = 2'b00; dread_req = 1'b0; iread_req = 1'b0;
        total++;
        if (ord[0] !== 1 || ord[1] !== 2 || ord[2] !== 3 || ord[3] !== 4) begin
            bad++; $display("FAIL prio_order: got %0d%0d%0d%0d expected 1234", ord[0], ord[1], ord[2], ord[3]);
        end
        total++;
        if (at[0] !== 2 || at[1] !== 5 || at[2] !== 9 || at[3] !== 14) begin
            bad++; $display("FAIL prio_timing: got %0d,%0d,%0d,%0d expected 2,5,9,14", at[0], at[1], at[2], at[3]);
        end
        total++;
        if ({rd, fd} !== 40'h2211_332211) begin
            bad++; $display("FAIL prio_data: got %h/%h expected 2211/332211", rd, fd);
        end
        total++;
        if ({mem[16'h0050], mem[16'h0060]} !== 16'h5CA5) begin
            bad++; $display("FAIL prio_writes: got %h expected 5ca5", {mem[16'h0050], mem[16'h0060]});
        end
        @(negedge clk);
    endtask

    task automatic test_starvation();
        int reads = 0;
        logic got_fetch = 1'b0;
        logic [23:0] fd;
        fd = '0;
        iread_addr = 16'h0010; iread_req = 1'b1;
        dread_addr = 16'h0020; dread_req = 1'b1;
        for (int i = 0; i < 100 && !got_fetch; i++) begin
            @(negedge clk);
            if (dread_valid) begin
                reads++; dread_req = 1'b0;
            end else if (ivalid) begin
                got_fetch = 1'b1; fd = iread_data;
                iread_req = 1'b0; dread_req = 1'b0;
            end else if (!dread_req) begin
                dread_req = 1'b1;
            end
        end
        iread_req = 1'b0; dread_req = 1'b0;
        total++;
        if (!got_fetch || reads !== 4) begin
            bad++; $display("FAIL starve_force: got fetch=%b reads=%0d expected 1/4", got_fetch, reads);
        end
        total++;
        if (fd !== 24'h332211 || dread_data !== 16'hBEEF) begin
            bad++; $display("FAIL starve_data: got %h/%h expected 332211/beef", fd, dread_data);
        end
        @(negedge clk);
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL starve_idle: got busy=%b expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        logic seen = 1'b0;
        iread_addr = 16'h0010; iread_req = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, ivalid, mem_we, mem_addr, iread_data} !== 43'h0) begin
            bad++; $display("FAIL reset_async: got busy=%b ivalid=%b we=%b addr=%h data=%h expected all 0",
                            busy, ivalid, mem_we, mem_addr, iread_data);
        end
        repeat (3) begin @(negedge clk); if (ivalid) seen = 1'b1; end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); n++;
            if (ivalid) break;
        end
        iread_req = 1'b0;
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL reset_no_strobe: got ivalid during reset"); end
        total++;
        if (n !== 4 || iread_data !== 24'h332211) begin
            bad++; $display("FAIL reset_restart: got latency=%0d data=%h expected 4/332211", n, iread_data);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_dwrite_dread();
        test_partial_wrap();
        test_priority();
        test_starvation();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
